// File: rtl/dmem_responder_if.sv
// Load/store bus between the core's memory stage and the data-memory responder.
// The misaligned response flag exists only when DMEM_ALIGN_CHECK_EN is defined.
interface dmem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;
  logic        busy;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        misaligned;

  modport master (
    output MemRead, MemWrite, address, writeData,
    input  readData, ready, busy, misaligned
  );

  modport slave (
    input  MemRead, MemWrite, address, writeData,
    output readData, ready, busy, misaligned
  );
`else
  modport master (
    output MemRead, MemWrite, address, writeData,
    input  readData, ready, busy
  );

  modport slave (
    input  MemRead, MemWrite, address, writeData,
    output readData, ready, busy
  );
`endif
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with a ready handshake and programmable wait states.
// One request in flight: IDLE accepts, WAIT burns WAIT_STATES cycles, RESP
// strobes ready for one cycle. Memory is word organised, indexed by
// address[ADDR_WIDTH+1:2]; higher address bits alias.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (flags and suppresses accesses
// whose address[1:0] is non-zero).
module dmem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input logic              clk,
  input logic              reset,
  dmem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           data_q;
  logic                  write_q;
  logic                  mis_q;
  logic [31:0]           read_data;
  logic [31:0]           mem [DEPTH];

  logic                  req;
  logic [ADDR_WIDTH-1:0] live_idx;
  logic                  live_mis;

  logic                  go_resp;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic [31:0]           c_data;
  logic                  c_write;
  logic                  c_mis;

  assign req      = bus.MemRead | bus.MemWrite;
  assign live_idx = ADDR_WIDTH'(bus.address >> 2);
`ifdef DMEM_ALIGN_CHECK_EN
  assign live_mis = (bus.address[1:0] != 2'b00);
`else
  assign live_mis = 1'b0;
`endif

  // Decide whether this edge enters RESP and which request fields commit;
  // with zero wait states the live inputs commit directly from IDLE.
  always_comb begin
    go_resp = 1'b0;
    c_idx   = idx_q;
    c_data  = data_q;
    c_write = write_q;
    c_mis   = mis_q;
    if (state == ST_IDLE && req && WAIT_STATES == 0) begin
      go_resp = 1'b1;
      c_idx   = live_idx;
      c_data  = bus.writeData;
      c_write = bus.MemWrite;
      c_mis   = live_mis;
    end else if (state == ST_WAIT && cnt == '0) begin
      go_resp = 1'b1;
    end
  end

  // Handshake state machine plus the request fields latched on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            idx_q   <= live_idx;
            data_q  <= bus.writeData;
            write_q <= bus.MemWrite;
            mis_q   <= live_mis;
            if (WAIT_STATES == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_W'(WAIT_STATES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_RESP;
          else           cnt   <= cnt - CNT_W'(1);
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Commit stores on the RESP-entry edge; a reset on that edge drops them.
  always_ff @(posedge clk) begin
    if (go_resp && c_write && !c_mis && !reset) begin
      mem[c_idx] <= c_data;
    end
  end

  // Load data updates only on a read response (or a flagged misaligned one).
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data <= '0;
    end else if (go_resp && (!c_write || c_mis)) begin
      read_data <= c_mis ? 32'h0 : mem[c_idx];
    end
  end

  assign bus.readData = read_data;
  assign bus.ready    = (state == ST_RESP);
  assign bus.busy     = (state != ST_IDLE);
`ifdef DMEM_ALIGN_CHECK_EN
  assign bus.misaligned = (state == ST_RESP) && mis_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Two instances run side by side on
// the same request stream: one with WAIT_STATES=2, one with WAIT_STATES=0.
// Each has its own reference memory and a scoreboard queue of expected
// responses that is drained when the DUT raises ready.
module tb_dmem_responder;

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] model_a [256];
  logic [31:0] model_b [256];
  logic [31:0] last_rd_a;
  logic [31:0] last_rd_b;

  dmem_responder_if ifa ();
  dmem_responder_if ifb ();

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut_ws2 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut_ws0 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter: value seen at a negedge equals the number of edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard for the WAIT_STATES=2 instance: every ready pops one expectation.
  always @(negedge clk) begin
    if (ifa.ready === 1'b1) begin
      if (qa.size() == 0) begin
        checkOutput("ready_a_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        checkOutput("latency_a", cyc, e.cyc);
        checkOutput("readData_a", ifa.readData, e.rd);
`ifdef DMEM_ALIGN_CHECK_EN
        checkOutput("misaligned_a", {31'b0, ifa.misaligned}, {31'b0, e.mis});
`endif
      end
    end
  end

  // Scoreboard for the WAIT_STATES=0 instance.
  always @(negedge clk) begin
    if (ifb.ready === 1'b1) begin
      if (qb.size() == 0) begin
        checkOutput("ready_b_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        checkOutput("latency_b", cyc, e.cyc);
        checkOutput("readData_b", ifb.readData, e.rd);
`ifdef DMEM_ALIGN_CHECK_EN
        checkOutput("misaligned_b", {31'b0, ifb.misaligned}, {31'b0, e.mis});
`endif
      end
    end
  end

  task automatic driveBus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    ifa.MemRead = rd;  ifa.MemWrite = wr;  ifa.address = addr;  ifa.writeData = data;
    ifb.MemRead = rd;  ifb.MemWrite = wr;  ifb.address = addr;  ifb.writeData = data;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy_a"}, {31'b0, ifa.busy}, 32'd0);
    checkOutput({tag, "_busy_b"}, {31'b0, ifb.busy}, 32'd0);
    checkOutput({tag, "_ready_a"}, {31'b0, ifa.ready}, 32'd0);
    checkOutput({tag, "_ready_b"}, {31'b0, ifb.ready}, 32'd0);
    checkOutput({tag, "_hold_a"}, ifa.readData, last_rd_a);
    checkOutput({tag, "_hold_b"}, ifb.readData, last_rd_b);
`ifdef DMEM_ALIGN_CHECK_EN
    checkOutput({tag, "_mis_a"}, {31'b0, ifa.misaligned}, 32'd0);
    checkOutput({tag, "_mis_b"}, {31'b0, ifb.misaligned}, 32'd0);
`endif
  endtask

  // Issue one transaction to both instances, predict results, hold each
  // request until that instance answers, then confirm both return to IDLE.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic [7:0] idx;
    logic       mis;
    logic       pend_a;
    logic       pend_b;
    exp_t       ea;
    exp_t       eb;
    idx = addr[9:2];
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    @(negedge clk);
    ea.cyc = cyc + 3;
    eb.cyc = cyc + 1;
    ea.mis = mis;
    eb.mis = mis;
    if (mis) begin
      ea.rd = 32'h0;
      eb.rd = 32'h0;
    end else if (wr) begin
      ea.rd = last_rd_a;
      eb.rd = last_rd_b;
      model_a[idx] = data;
      model_b[idx] = data;
    end else begin
      ea.rd = model_a[idx];
      eb.rd = model_b[idx];
    end
    last_rd_a = ea.rd;
    last_rd_b = eb.rd;
    qa.push_back(ea);
    qb.push_back(eb);
    driveBus(rd, wr, addr, data);
    pend_a = 1'b1;
    pend_b = 1'b1;
    for (int n = 0; n < 20 && (pend_a || pend_b); n++) begin
      @(negedge clk);
      if (pend_a) begin
        checkOutput("busy_a", {31'b0, ifa.busy}, 32'd1);
        if (ifa.ready === 1'b1) begin
          pend_a = 1'b0;
          ifa.MemRead = 1'b0;
          ifa.MemWrite = 1'b0;
        end
      end
      if (pend_b) begin
        checkOutput("busy_b", {31'b0, ifb.busy}, 32'd1);
        if (ifb.ready === 1'b1) begin
          pend_b = 1'b0;
          ifb.MemRead = 1'b0;
          ifb.MemWrite = 1'b0;
        end
      end
    end
    checkOutput("response_seen", {30'b0, pend_a, pend_b}, 32'd0);
    driveBus(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkIdle("idle");
  endtask

  // Reset lands while the slow instance is in WAIT and the fast one in RESP:
  // the slow store is lost, the fast store was already committed.
  task automatic resetMidOp();
    exp_t eb;
    @(negedge clk);
    eb.cyc = cyc + 1;
    eb.rd  = last_rd_b;
    eb.mis = 1'b0;
    qb.push_back(eb);
    model_b[8'h10] = 32'h55;
    driveBus(1'b0, 1'b1, 32'h40, 32'h55);
    @(negedge clk);
    checkOutput("rst_wait_busy_a", {31'b0, ifa.busy}, 32'd1);
    checkOutput("rst_wait_ready_a", {31'b0, ifa.ready}, 32'd0);
    checkOutput("rst_resp_ready_b", {31'b0, ifb.ready}, 32'd1);
    driveBus(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_rd_a = 32'h0;
    last_rd_b = 32'h0;
    checkIdle("rst_after");
    @(negedge clk);
    checkIdle("rst_settled");
    checkOutput("rst_queue_b", qb.size(), 32'd0);
  endtask

  initial begin
    int          errs;
    logic [31:0] a;
    logic [31:0] d;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    last_rd_a = 32'h0;
    last_rd_b = 32'h0;
    reset     = 1'b1;
    driveBus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    checkIdle("reset");
    reset = 1'b0;
    @(negedge clk);
    checkIdle("post_reset");

    $display("[TB] write/read with wait states");
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);

    $display("[TB] second word and re-read");
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);

    $display("[TB] both requests high, write wins");
    applyStimulus(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);

    $display("[TB] reset in the middle of a write");
    applyStimulus(1'b0, 1'b1, 32'h40, 32'h11);
    resetMidOp();
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);

    $display("[TB] address aliasing");
    applyStimulus(1'b0, 1'b1, 32'h004, 32'h77);
    applyStimulus(1'b1, 1'b0, 32'h404, 32'h0);

    $display("[TB] back-to-back read-after-write");
    for (int i = 0; i < 8; i++) begin
      a = $urandom & 32'hFFFF_FFFC;
      d = $urandom;
      applyStimulus(1'b0, 1'b1, a, d);
      applyStimulus(1'b1, 1'b0, a, 32'h0);
    end

`ifdef DMEM_ALIGN_CHECK_EN
    $display("[TB] misaligned write is flagged and dropped");
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h13, 32'hFF);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
`endif

    errs = qa.size() + qb.size();
    checkOutput("queues_drained", errs, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on run time in case the DUT never responds.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
